ysyx_22041752_icache: RTL and testbench
=======================================

# ysyx_22041752_icache

Direct-mapped, read-only instruction cache between the IFU and the AXI arbiter's instruction port. Hits are served from on-chip arrays in the cycle after the request. Misses issue a single 64-bit fetch over the arbiter's `inst_en`/`inst_resp` handshake and fill the line. It supports whole-cache invalidation for `fence.i` and an uncached bypass for MMIO.

## Interface
Parameters:
- `NLINES`, 64: number of lines. Power of two. One 64-bit word per line.
- `IDX_WD`, 6: log2(`NLINES`).
- `UNCACHED_MSB`, 1'b0: addresses with `addr[31]` equal to this value bypass the cache.

Ports:
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-low.
- `cpu_en` input 1: fetch request (IFU side).
- `cpu_addr` input 64: fetch address. Only bits [31:3] are used.
- `cpu_resp` output 1: one-cycle pulse; `cpu_rdata` is valid while it is high.
- `cpu_rdata` output 64: aligned 64-bit word containing the instruction.
- `fence_i` input 1: one-cycle invalidate-all pulse.
- `mem_en` output 1: connects to arbiter `inst_en`.
- `mem_addr` output 64: connects to arbiter `inst_addr`. Value is {32'b0, req_addr[31:3], 3'b0}.
- `mem_resp` input 1: connects to arbiter `inst_resp`.
- `mem_rdata` input 64: connects to arbiter `inst_rdata`.

## Operation
Address split:
- tag = addr[31:3+IDX_WD]
- index = addr[3+IDX_WD-1:3]
- addr[2:0] is ignored.

Storage:
- `valid[NLINES]` flops, cleared by reset.
- Tag and data arrays are flops without reset.

Registers:
- `req_addr` (32b)
- `fill_buf` (64b)
- `fence_pend` (1b)
- `state`

FSM (`state` resets to IDLE):
- **IDLE**
  - If `fence_i` or `fence_pend` is set: clear all `valid`, clear `fence_pend`, stay in IDLE. `cpu_en` is not accepted this cycle.
  - Else if `cpu_en`: latch `req_addr <= cpu_addr[31:0]` and go to LOOKUP.
- **LOOKUP**
  - hit = `valid[idx] && tag_arr[idx]==tag && req_addr[31]!=UNCACHED_MSB`.
  - On hit: `cpu_resp=1`, `cpu_rdata=data_arr[idx]`, go to IDLE.
  - Otherwise go to MISS.
- **MISS**
  - `mem_en=1`, `mem_addr` driven from `req_addr`, held stable throughout.
  - On `mem_resp`: `fill_buf <= mem_rdata`, go to REFILL.
  - If the address is cacheable, also write `data_arr[idx]=mem_rdata`, `tag_arr[idx]=tag`, `valid[idx]=1`.
  - An uncached response does not touch the arrays.
- **REFILL**
  - `cpu_resp=1`, `cpu_rdata=fill_buf`, go to IDLE.

Rules:
- The IFU holds `cpu_en` and `cpu_addr` stable until `cpu_resp`. The cache uses only the latched `req_addr` after acceptance.
- `cpu_en` still high in the IDLE cycle after `cpu_resp` is treated as a new request. The IFU deasserts it or changes the address as needed.
- `fence_i` arriving outside IDLE sets `fence_pend`. A line filled in the same MISS is therefore invalidated before the next lookup.
- `fence_i` in IDLE together with `cpu_en`: the fence wins and the request is accepted in the next cycle.
- `mem_en` stays high for the whole MISS state. The arbiter samples it only in its own IDLE, so holding it is legal. `mem_en` drops in the cycle after `mem_resp`.
- `mem_resp` outside MISS is ignored.

## Timing
Reset values:
- `cpu_resp`=0, `cpu_rdata`=0, `mem_en`=0, `mem_addr`=0.
- `state`=IDLE, `valid`=all 0, `fence_pend`=0, `fill_buf`=0.

Reset asserted mid-MISS:
- FSM goes to IDLE immediately (async) and `mem_en` drops.
- The arbiter is reset by the same net, so no orphan response is expected.

Latency and throughput:
- Hit latency: request accepted at edge N (IDLE→LOOKUP); `cpu_resp` is high during cycle N+1. This gives one access per 2 cycles.
- Miss latency: accept at N, LOOKUP during N+1, MISS from N+2. With `mem_resp` in cycle M, `cpu_resp` is high in M+1 (REFILL) and the FSM is back in IDLE at M+2.

Output drive:
- `cpu_rdata` is combinational from the arrays in LOOKUP and from `fill_buf` in REFILL. It is 0 otherwise.
- `cpu_resp` is never high for two consecutive cycles.

## Test plan
- Cold miss: reset, `cpu_en` with addr 0x8000_0008; memory returns 0x1111_2222_3333_4444 after 5 cycles. Expect one `mem_en` episode with `mem_addr` 0x8000_0008, then `cpu_resp` one cycle after `mem_resp` carrying that data.
- Hit: repeat addr 0x8000_000C (same word). Expect `cpu_resp` in the cycle after acceptance, data 0x1111_2222_3333_4444, and `mem_en` stays 0.
- Conflict: fetch 0x8000_0008, then 0x8000_0208 (same index, NLINES=64), then 0x8000_0008 again. Expect three misses, each with the correct `mem_addr`.
- Fence: fill 0x8000_0010, pulse `fence_i` while a miss to 0x8000_0018 is in flight, then fetch 0x8000_0010 and 0x8000_0018. Expect both to miss.
- Bypass: fetch 0x0000_1000 twice. Expect two memory requests, both responses forwarded, and `valid[0]` still 0.
- Async reset mid-MISS: assert `reset`=0 while `mem_en`=1. Expect `mem_en`=0, `cpu_resp`=0 and `valid`=0 immediately (no clock edge), and a fresh miss after reset is released.

Source files
------------

// File: rtl/ysyx_22041752_icache.sv
// Direct-mapped read-only instruction cache, one 64-bit word per line.
// Misses and uncached fetches go out over the arbiter's instruction port.
module ysyx_22041752_icache #(
  parameter int   NLINES       = 64,
  parameter int   IDX_WD       = 6,
  parameter logic UNCACHED_MSB = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [63:0] cpu_addr,
  output logic        cpu_resp,
  output logic [63:0] cpu_rdata,
  input  logic        fence_i,
  output logic        mem_en,
  output logic [63:0] mem_addr,
  input  logic        mem_resp,
  input  logic [63:0] mem_rdata
);

  localparam int TAG_WD = 29 - IDX_WD;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_e;

  state_e             state_q, state_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [63:0]        fill_buf_q, fill_buf_d;
  logic               fence_pend_q, fence_pend_d;
  logic [NLINES-1:0]  valid_q, valid_d;
  logic [TAG_WD-1:0]  tag_arr_q [NLINES];
  logic [63:0]        data_arr_q [NLINES];

  logic [IDX_WD-1:0]  idx;
  logic [TAG_WD-1:0]  tag;
  logic               cacheable;
  logic               hit;
  logic               fill_we;
  logic [NLINES-1:0]  line_fill;

  assign idx       = req_addr_q[3+IDX_WD-1:3];
  assign tag       = req_addr_q[31:3+IDX_WD];
  assign cacheable = (req_addr_q[31] != UNCACHED_MSB);
  assign hit       = valid_q[idx] && (tag_arr_q[idx] == tag) && cacheable;
  assign fill_we   = (state_q == MISS) && mem_resp && cacheable;

  // One-hot set mask for the line being filled this cycle.
  for (genvar gi = 0; gi < NLINES; gi++) begin : g_fill
    assign line_fill[gi] = fill_we && (idx == IDX_WD'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      fill_buf_q   <= '0;
      fence_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      fill_buf_q   <= fill_buf_d;
      fence_pend_q <= fence_pend_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_arr_q[idx]  <= tag;
      data_arr_q[idx] <= mem_rdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    fill_buf_d   = fill_buf_q;
    fence_pend_d = fence_pend_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE: begin
        if (fence_i || fence_pend_q) begin
          valid_d      = '0;
          fence_pend_d = 1'b0;
        end else if (cpu_en) begin
          req_addr_d = cpu_addr[31:0];
          state_d    = LOOKUP;
        end
      end
      LOOKUP: state_d = hit ? IDLE : MISS;
      MISS: begin
        if (mem_resp) begin
          fill_buf_d = mem_rdata;
          valid_d    = valid_q | line_fill;
          state_d    = REFILL;
        end
      end
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A fence seen mid-transaction is replayed on the next IDLE cycle.
    if (state_q != IDLE && fence_i) begin
      fence_pend_d = 1'b1;
    end
  end

  always_comb begin
    cpu_resp  = 1'b0;
    cpu_rdata = '0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    case (state_q)
      LOOKUP: begin
        if (hit) begin
          cpu_resp  = 1'b1;
          cpu_rdata = data_arr_q[idx];
        end
      end
      MISS: begin
        mem_en   = 1'b1;
        mem_addr = {32'b0, req_addr_q[31:3], 3'b000};
      end
      REFILL: begin
        cpu_resp  = 1'b1;
        cpu_rdata = fill_buf_q;
      end
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[63:32], cpu_addr[2:0], req_addr_q[2:0]};

endmodule

// File: tb/tb_ysyx_22041752_icache.sv
// Bench for ysyx_22041752_icache: table of fetches with a responding memory
// model, a response scoreboard, and hand sequences for reset corner cases.
module tb_ysyx_22041752_icache;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic [63:0] cpu_addr;
  logic        cpu_resp;
  logic [63:0] cpu_rdata;
  logic        fence_i;
  logic        mem_en;
  logic [63:0] mem_addr;
  logic        mem_resp;
  logic [63:0] mem_rdata;

  ysyx_22041752_icache dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_en    (cpu_en),
    .cpu_addr  (cpu_addr),
    .cpu_resp  (cpu_resp),
    .cpu_rdata (cpu_rdata),
    .fence_i   (fence_i),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_resp  (mem_resp),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    int          lat;
    logic [63:0] mem_data;
    logic [63:0] exp_data;
    int          fence_at;   // negedge index to pulse fence_i, -1 for none
  } vec_t;

  localparam logic [63:0] JUNK = 64'hDEAD_DEAD_DEAD_DEAD;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q [$];
  vec_t        vecs [$];

  function automatic vec_t mk(input logic [31:0] a, input bit m, input int l,
                              input logic [63:0] md, input logic [63:0] ed, input int fa);
    vec_t v;
    v.addr = a; v.miss = m; v.lat = l; v.mem_data = md; v.exp_data = ed; v.fence_at = fa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          k, cnt, shift, exp_k, resp_k, addr_err;
    logic [63:0] exp_ma;
    exp_ma   = {32'b0, v.addr[31:3], 3'b000};
    shift    = (v.fence_at == 0) ? 1 : 0;
    exp_k    = shift + (v.miss ? 2 + v.lat : 1);
    k = 0; cnt = 0; resp_k = -1; addr_err = 0;
    @(negedge clk);
    cpu_en   = 1'b1;
    cpu_addr = {32'hDEAD_BEEF, v.addr};
    mem_resp = 1'b0;
    fence_i  = (v.fence_at == 0);
    exp_q.push_back(v.exp_data);
    while (resp_k < 0 && k < 60) begin
      @(negedge clk);
      k++;
      mem_resp = 1'b0;
      fence_i  = (k == v.fence_at);
      if (mem_en) begin
        cnt++;
        if (mem_addr !== exp_ma) addr_err++;
        if (cnt == ((v.lat == 0) ? 1 : v.lat)) begin
          mem_resp  = 1'b1;
          mem_rdata = v.mem_data;
        end
      end
      if (cpu_resp) begin
        resp_k = k;
        cpu_en = 1'b0;
        if (exp_q.size() == 0) chk($sformatf("v%0d unexpected_resp", id), 64'd1, 64'd0);
        else chk($sformatf("v%0d rdata", id), cpu_rdata, exp_q.pop_front());
      end
    end
    fence_i = 1'b0;
    if (resp_k < 0) begin
      cpu_en = 1'b0;
      if (exp_q.size() > 0) exp_q.delete(0);
    end
    chk($sformatf("v%0d resp_cycle", id), 64'(resp_k), 64'(exp_k));
    chk($sformatf("v%0d mem_en_cycles", id), 64'(cnt), 64'(v.miss ? v.lat : 0));
    chk($sformatf("v%0d mem_addr_errs", id), 64'(addr_err), 64'd0);
    $display("[TB] v%0d addr=%h miss=%0d resp_cycle=%0d mem_cycles=%0d", id, v.addr, v.miss, resp_k, cnt);
    @(negedge clk);
    chk($sformatf("v%0d resp_pulse", id), 64'(cpu_resp), 64'd0);
    chk($sformatf("v%0d mem_en_idle", id), 64'(mem_en), 64'd0);
    // Stray response while idle must be ignored.
    mem_resp  = 1'b1;
    mem_rdata = JUNK;
  endtask

  int k;

  initial begin
    clk = 0; reset = 0; cpu_en = 0; cpu_addr = '0; fence_i = 0; mem_resp = 0; mem_rdata = '0;

    vecs.push_back(mk(32'h8000_0008, 1, 5, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, -1));
    vecs.push_back(mk(32'h8000_000C, 0, 0, JUNK,                    64'h1111_2222_3333_4444, -1));
    vecs.push_back(mk(32'h8000_0208, 1, 2, 64'hAAAA_BBBB_CCCC_0208, 64'hAAAA_BBBB_CCCC_0208, -1));
    vecs.push_back(mk(32'h8000_0008, 1, 3, 64'h1111_2222_3333_4445, 64'h1111_2222_3333_4445, -1));
    vecs.push_back(mk(32'h8000_0008, 0, 0, JUNK,                    64'h1111_2222_3333_4445, -1));
    vecs.push_back(mk(32'h8000_0010, 1, 1, 64'h0000_0010_0000_0004, 64'h0000_0010_0000_0004, -1));
    vecs.push_back(mk(32'h8000_0014, 0, 0, JUNK,                    64'h0000_0010_0000_0004, -1));
    vecs.push_back(mk(32'h8000_0018, 1, 4, 64'h0000_0018_0000_0005, 64'h0000_0018_0000_0005,  3));
    vecs.push_back(mk(32'h8000_0010, 1, 2, 64'h0000_0010_0000_0006, 64'h0000_0010_0000_0006, -1));
    vecs.push_back(mk(32'h8000_0018, 1, 2, 64'h0000_0018_0000_0007, 64'h0000_0018_0000_0007, -1));
    vecs.push_back(mk(32'h8000_0018, 0, 0, JUNK,                    64'h0000_0018_0000_0007, -1));
    vecs.push_back(mk(32'h0000_1000, 1, 2, 64'hB1B1_0000_1000_0008, 64'hB1B1_0000_1000_0008, -1));
    vecs.push_back(mk(32'h0000_1000, 1, 1, 64'hB2B2_0000_1000_0009, 64'hB2B2_0000_1000_0009, -1));
    vecs.push_back(mk(32'h8000_0010, 0, 0, JUNK,                    64'h0000_0010_0000_0006, -1));
    vecs.push_back(mk(32'h8000_0010, 1, 1, 64'h0000_0010_0000_000A, 64'h0000_0010_0000_000A,  0));
    vecs.push_back(mk(32'h8000_01F8, 1, 1, 64'h0000_01F8_0000_000B, 64'h0000_01F8_0000_000B, -1));
    vecs.push_back(mk(32'h8000_01FF, 0, 0, JUNK,                    64'h0000_01F8_0000_000B, -1));
    vecs.push_back(mk(32'hFFFF_FFF8, 1, 2, 64'hFFFF_FFF8_0000_000C, 64'hFFFF_FFF8_0000_000C, -1));
    vecs.push_back(mk(32'h8000_01F8, 1, 1, 64'h0000_01F8_0000_000D, 64'h0000_01F8_0000_000D, -1));

    #1;
    chk("reset cpu_resp",  64'(cpu_resp), 64'd0);
    chk("reset cpu_rdata", cpu_rdata,     64'd0);
    chk("reset mem_en",    64'(mem_en),   64'd0);
    chk("reset mem_addr",  mem_addr,      64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
      if (i == 12) chk("bypass valid0", 64'(dut.valid_q[0]), 64'd0);
    end

    // Asynchronous reset while a miss is outstanding.
    @(negedge clk);
    cpu_en   = 1'b1;
    cpu_addr = {32'h0, 32'h8000_0020};
    mem_resp = 1'b0;
    k = 0;
    while (!mem_en && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst pre mem_en", 64'(mem_en), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst mem_en",    64'(mem_en),     64'd0);
    chk("rst cpu_resp",  64'(cpu_resp),   64'd0);
    chk("rst cpu_rdata", cpu_rdata,       64'd0);
    chk("rst mem_addr",  mem_addr,        64'd0);
    chk("rst valid",     64'(dut.valid_q), 64'd0);
    $display("[TB] async reset mid-miss: mem_en=%0d cpu_resp=%0d", mem_en, cpu_resp);
    cpu_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_vec(100, mk(32'h8000_0010, 1, 2, 64'h0000_0010_0000_000E, 64'h0000_0010_0000_000E, -1));
    run_vec(101, mk(32'h8000_0010, 0, 0, JUNK,                    64'h0000_0010_0000_000E, -1));

    chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
